// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and access sequencer sharing one RAM/UART bus between CPU (M0) and loader (M1).
// Each grant runs IDLE -> ACCESS (region-dependent wait) -> ACK, with every output registered.
module mem_bus_arbiter #(
  parameter logic [15:0] UART_BASE = 16'hFF80,
  parameter int unsigned WAIT_RAM  = 1,
  parameter int unsigned WAIT_IO   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_be,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_gnt,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_be,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_gnt,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  output logic        bus_be,
  input  logic [15:0] bus_rdata
);

  localparam logic [3:0] LP_WAIT_RAM = 4'(WAIT_RAM);
  localparam logic [3:0] LP_WAIT_IO  = 4'(WAIT_IO);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic [15:0] r_bus_addr;
  logic [15:0] r_bus_wdata;
  logic        r_bus_we;
  logic        r_bus_re;
  logic        r_bus_be;
  logic [15:0] r_m0_rdata;
  logic [15:0] r_m1_rdata;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic        r_m0_gnt;
  logic        r_m1_gnt;

  logic        w_pick_m1;
  logic        w_we;
  logic        w_be;
  logic [15:0] w_addr;
  logic [15:0] w_wdata;
  logic [3:0]  w_wait;

  // On a tie the master that did not win last time gets the bus.
  assign w_pick_m1 = m1_req & (~m0_req | ~r_last);
  assign w_we      = w_pick_m1 ? m1_we    : m0_we;
  assign w_be      = w_pick_m1 ? m1_be    : m0_be;
  assign w_addr    = w_pick_m1 ? m1_addr  : m0_addr;
  assign w_wdata   = w_pick_m1 ? m1_wdata : m0_wdata;
  assign w_wait    = (w_addr >= UART_BASE) ? LP_WAIT_IO : LP_WAIT_RAM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= 4'd0;
      r_bus_addr  <= 16'h0000;
      r_bus_wdata <= 16'h0000;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_bus_be    <= 1'b0;
      r_m0_rdata  <= 16'h0000;
      r_m1_rdata  <= 16'h0000;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_bus_addr  <= w_addr;
            r_bus_wdata <= w_wdata;
            r_bus_be    <= w_be;
            r_bus_we    <= w_we;
            r_bus_re    <= ~w_we;
            r_owner     <= w_pick_m1;
            r_last      <= w_pick_m1;
            r_m0_gnt    <= ~w_pick_m1;
            r_m1_gnt    <= w_pick_m1;
            r_cnt       <= w_wait;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Writes also capture the bus so both access kinds finish identically.
            if (r_owner) begin
              r_m1_rdata <= bus_rdata;
              r_m1_ack   <= 1'b1;
            end else begin
              r_m0_rdata <= bus_rdata;
              r_m0_ack   <= 1'b1;
            end
            r_bus_we <= 1'b0;
            r_bus_re <= 1'b0;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_m0_gnt <= 1'b0;
          r_m1_gnt <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign bus_be    = r_bus_be;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps then random traffic, checked each cycle
// against a transaction-timeline model (start cycle, wait length, owner, captured data).
module tb_mem_bus_arbiter;

  localparam logic [15:0] UART_BASE = 16'hFF80;
  localparam int WAIT_RAM = 1;
  localparam int WAIT_IO  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_be = 1'b0;
  logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0;
  logic [15:0] m0_rdata;
  logic        m0_ack, m0_gnt;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_be = 1'b0;
  logic [15:0] m1_addr = 16'h0, m1_wdata = 16'h0;
  logic [15:0] m1_rdata;
  logic        m1_ack, m1_gnt;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_we, bus_re, bus_be;
  logic [15:0] bus_rdata = 16'h0;

  mem_bus_arbiter #(
    .UART_BASE(UART_BASE),
    .WAIT_RAM (WAIT_RAM),
    .WAIT_IO  (WAIT_IO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_gnt(m1_gnt),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_be(bus_be), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: the current transaction is described by its IDLE sampling cycle,
  // its wait count and owner; every expected output follows from those numbers.
  int          txStart = -100;
  int          txW = 0;
  int          txMaster = 0;
  int          nextIdle = 0;
  int          lastGrant = 1;
  logic        txWe = 1'b0, txBe = 1'b0;
  logic [15:0] txAddr = 16'h0, txWdata = 16'h0;
  logic [15:0] expRdata [2] = '{16'h0, 16'h0};

  int          mode = 0;
  bit          fixedRdataEn = 1'b0;
  logic [15:0] fixedRdata = 16'h0;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] randAddr();
    logic [15:0] a;
    case ($urandom_range(0, 5))
      0: a = 16'h0010;
      1: a = 16'hFF7F;
      2: a = 16'hFF80;
      3: a = 16'hFFFF;
      4: a = 16'hFF82;
      default: a = 16'($urandom);
    endcase
    return a;
  endfunction

  task automatic applyStimulus(input int m, input logic we, input logic be,
                               input logic [15:0] addr, input logic [15:0] wdata);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic newCommand(input int m);
    applyStimulus(m, 1'($urandom), 1'($urandom), randAddr(), 16'($urandom));
  endtask

  task automatic masterStep(input int m, input bit acked);
    logic req;
    req = (m == 0) ? m0_req : m1_req;
    if (acked) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) newCommand(m);
      else if (m == 0) m0_req = 1'b0;
      else m1_req = 1'b0;
    end else if (!req && mode == 2 && $urandom_range(0, 2) == 0) begin
      newCommand(m);
    end
  endtask

  task automatic checkOutput(input bit inAcc, input bit inAck);
    check1("m0_gnt", m0_gnt, (inAcc || inAck) && txMaster == 0);
    check1("m1_gnt", m1_gnt, (inAcc || inAck) && txMaster == 1);
    check1("m0_ack", m0_ack, inAck && txMaster == 0);
    check1("m1_ack", m1_ack, inAck && txMaster == 1);
    check1("bus_we", bus_we, inAcc && txWe);
    check1("bus_re", bus_re, inAcc && !txWe);
    check16("m0_rdata", m0_rdata, expRdata[0]);
    check16("m1_rdata", m1_rdata, expRdata[1]);
    if (inAcc) begin
      check16("bus_addr", bus_addr, txAddr);
      check16("bus_wdata", bus_wdata, txWdata);
      check1("bus_be", bus_be, txBe);
    end
  endtask

  task automatic stepCycle();
    bit inAcc, inAck;
    int winner;
    @(negedge clk);
    inAcc = (cyc >= txStart + 1) && (cyc <= txStart + txW + 1);
    inAck = (cyc == txStart + txW + 2);
    checkOutput(inAcc, inAck);
    masterStep(0, inAck && txMaster == 0);
    masterStep(1, inAck && txMaster == 1);
    bus_rdata = fixedRdataEn ? fixedRdata : 16'($urandom);
    if (cyc == txStart + txW + 1) expRdata[txMaster] = bus_rdata;
    if (cyc >= nextIdle && (m0_req || m1_req)) begin
      if (m0_req && m1_req) winner = 1 - lastGrant;
      else winner = m0_req ? 0 : 1;
      lastGrant = winner;
      txMaster  = winner;
      txWe      = (winner == 0) ? m0_we    : m1_we;
      txBe      = (winner == 0) ? m0_be    : m1_be;
      txAddr    = (winner == 0) ? m0_addr  : m1_addr;
      txWdata   = (winner == 0) ? m0_wdata : m1_wdata;
      txW       = (txAddr >= UART_BASE) ? WAIT_IO : WAIT_RAM;
      txStart   = cyc;
      nextIdle  = cyc + txW + 3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic checkAllZero();
    check1("rst_m0_gnt", m0_gnt, 1'b0);
    check1("rst_m1_gnt", m1_gnt, 1'b0);
    check1("rst_m0_ack", m0_ack, 1'b0);
    check1("rst_m1_ack", m1_ack, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check1("rst_bus_re", bus_re, 1'b0);
    check1("rst_bus_be", bus_be, 1'b0);
    check16("rst_bus_addr", bus_addr, 16'h0);
    check16("rst_bus_wdata", bus_wdata, 16'h0);
    check16("rst_m0_rdata", m0_rdata, 16'h0);
    check16("rst_m1_rdata", m1_rdata, 16'h0);
  endtask

  task automatic resetPulse();
    rst_n  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    #1;
    checkAllZero();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    txStart   = -100;
    txW       = 0;
    nextIdle  = 0;
    lastGrant = 1;
    expRdata  = '{16'h0, 16'h0};
    cyc++;
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    $display("[TB] simultaneous request after reset, M0 read of 0x0010");
    mode = 0;
    fixedRdataEn = 1'b1;
    fixedRdata = 16'h1234;
    applyStimulus(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 16'h0020, 16'h0);
    runCycles(12);
    fixedRdataEn = 1'b0;

    $display("[TB] region boundary and M1 byte write to UART");
    applyStimulus(1, 1'b0, 1'b0, 16'hFF7F, 16'h0);
    runCycles(6);
    applyStimulus(0, 1'b1, 1'b0, 16'hFF80, 16'hBEEF);
    runCycles(8);
    applyStimulus(1, 1'b1, 1'b1, 16'hFF82, 16'h0041);
    runCycles(8);

    $display("[TB] continuous requests from both masters");
    mode = 1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0100, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0200, 16'h5555);
    runCycles(24);
    mode = 0;
    runCycles(16);

    $display("[TB] req dropped mid-access, then reset mid-access");
    applyStimulus(0, 1'b0, 1'b0, 16'h0300, 16'h0);
    runCycles(2);
    m0_req = 1'b0;
    runCycles(5);
    applyStimulus(1, 1'b1, 1'b0, 16'hFF82, 16'h0041);
    runCycles(2);
    resetPulse();
    runCycles(6);

    $display("[TB] random traffic");
    mode = 2;
    runCycles(400);
    mode = 0;
    runCycles(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
